decode_pipe_stage: RTL and testbench

Parametrised decode stage for the in-order CPU pipeline. It sits between fetch and execute and splits the instruction into opcode, source and destination fields. It reads operands from an internal 2-read/1-write register file, applying writeback bypass and execute forwarding. It resolves equality branches, detects load-use hazards, and drives a registered D/E pipeline register with a valid/stall handshake toward execute.

---
 rtl/cpu_pkg.sv | 41 ++++
 rtl/decode_pipe_stage_if.sv | 58 +++++
 rtl/regfile_2r1w.sv | 37 +++
 rtl/decode_pipe_stage.sv | 178 +++++++++++++++++
 tb/tb_decode_pipe_stage.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU pipeline widths, opcodes and instruction field helpers
// Contents:
//   DATA_W/RA_W/OPC_W/PC_W : default datapath widths
//   LOAD_OPC/BR_OPC        : default load and branch-if-equal opcodes
//   inst_opc/inst_src1/inst_src2/inst_dest : slice fields out of [opc|src1|src2|dest]
package cpu_pkg;

    localparam int DATA_W = 16;
    localparam int RA_W   = 4;
    localparam int OPC_W  = 4;
    localparam int PC_W   = 12;

    localparam logic [3:0] LOAD_OPC = 4'hA;
    localparam logic [3:0] BR_OPC   = 4'hB;

    // Generic field extractor; callers cast the result to the field width.
    function automatic logic [31:0] inst_field(input logic [63:0] inst, input int lsb,
                                               input int width);
        logic [63:0] mask;
        mask = (64'd1 << width) - 64'd1;
        return 32'((inst >> lsb) & mask);
    endfunction

    function automatic logic [31:0] inst_opc(input logic [63:0] inst, input int ra_w,
                                             input int opc_w);
        return inst_field(inst, 3 * ra_w, opc_w);
    endfunction

    function automatic logic [31:0] inst_src1(input logic [63:0] inst, input int ra_w);
        return inst_field(inst, 2 * ra_w, ra_w);
    endfunction

    function automatic logic [31:0] inst_src2(input logic [63:0] inst, input int ra_w);
        return inst_field(inst, ra_w, ra_w);
    endfunction

    function automatic logic [31:0] inst_dest(input logic [63:0] inst, input int ra_w);
        return inst_field(inst, 0, ra_w);
    endfunction

endpackage

// File: rtl/decode_pipe_stage_if.sv
// rtl/decode_pipe_stage_if.sv - fetch/writeback/forward/execute signal bundle of the decode stage
// Signals:
//   fetch side   : in_valid, in_ready, inst, pc, imm_sel
//   writeback    : wb_en, wb_addr, wb_data
//   forward      : fwd_valid, fwd_addr, fwd_data
//   execute side : ex_stall, out_valid, out_opc, out_dest, out_src1, out_src2, out_pc
//   redirect     : br_taken, br_target
// Modports: slave = decode stage, master = surrounding pipeline.
interface decode_pipe_stage_if #(
    parameter int DATA_W = 16,
    parameter int RA_W   = 4,
    parameter int OPC_W  = 4,
    parameter int PC_W   = 12
);
    localparam int INST_W = OPC_W + 3 * RA_W;

    logic              in_valid;
    logic              in_ready;
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0]   pc;
    logic              imm_sel;
    logic              wb_en;
    logic [RA_W-1:0]   wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              fwd_valid;
    logic [RA_W-1:0]   fwd_addr;
    logic [DATA_W-1:0] fwd_data;
    logic              ex_stall;
    logic              out_valid;
    logic [OPC_W-1:0]  out_opc;
    logic [RA_W-1:0]   out_dest;
    logic [DATA_W-1:0] out_src1;
    logic [DATA_W-1:0] out_src2;
    logic [PC_W-1:0]   out_pc;
    logic              br_taken;
    logic [PC_W-1:0]   br_target;

    modport slave (
        input  in_valid, inst, pc, imm_sel,
        input  wb_en, wb_addr, wb_data,
        input  fwd_valid, fwd_addr, fwd_data,
        input  ex_stall,
        output in_ready,
        output out_valid, out_opc, out_dest, out_src1, out_src2, out_pc,
        output br_taken, br_target
    );

    modport master (
        output in_valid, inst, pc, imm_sel,
        output wb_en, wb_addr, wb_data,
        output fwd_valid, fwd_addr, fwd_data,
        output ex_stall,
        input  in_ready,
        input  out_valid, out_opc, out_dest, out_src1, out_src2, out_pc,
        input  br_taken, br_target
    );

endinterface

// File: rtl/regfile_2r1w.sv
// rtl/regfile_2r1w.sv - 2-read/1-write register file, R0 hardwired to zero
// Ports:
//   clk, reset         : clock, synchronous active-high reset (clears every register)
//   we_i/waddr_i/wdata_i : synchronous write port; writes to R0 are dropped
//   raddr1_i/rdata1_o  : asynchronous read port 1
//   raddr2_i/rdata2_o  : asynchronous read port 2
module regfile_2r1w #(
    parameter int DATA_W = 16,
    parameter int RA_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we_i,
    input  logic [RA_W-1:0]   waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [RA_W-1:0]   raddr1_i,
    output logic [DATA_W-1:0] rdata1_o,
    input  logic [RA_W-1:0]   raddr2_i,
    output logic [DATA_W-1:0] rdata2_o
);

    logic [DATA_W-1:0] mem_q [2**RA_W];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2**RA_W; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata1_o = (raddr1_i == '0) ? '0 : mem_q[raddr1_i];
    assign rdata2_o = (raddr2_i == '0) ? '0 : mem_q[raddr2_i];

endmodule

// File: rtl/decode_pipe_stage.sv
// rtl/decode_pipe_stage.sv - in-order CPU decode stage with operand select, hazards and D/E register
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   dp         : decode_pipe_stage_if.slave (fetch handshake, writeback, forward,
//                execute stall, D/E outputs, branch redirect)
// Build option: DECODE_BYPASS_EN defined -> writeback data bypasses into operand select;
//   undefined -> a writeback hitting a used source stalls decode one cycle instead.
module decode_pipe_stage #(
    parameter int               DATA_W   = cpu_pkg::DATA_W,
    parameter int               RA_W     = cpu_pkg::RA_W,
    parameter int               OPC_W    = cpu_pkg::OPC_W,
    parameter int               PC_W     = cpu_pkg::PC_W,
    parameter logic [OPC_W-1:0] LOAD_OPC = cpu_pkg::LOAD_OPC,
    parameter logic [OPC_W-1:0] BR_OPC   = cpu_pkg::BR_OPC
) (
    input  logic              clk,
    input  logic              reset,
    decode_pipe_stage_if.slave dp
);
    import cpu_pkg::*;

    logic [OPC_W-1:0]  f_opc;
    logic [RA_W-1:0]   f_src1;
    logic [RA_W-1:0]   f_src2;
    logic [RA_W-1:0]   f_dest;
    logic [DATA_W-1:0] rf_rd1;
    logic [DATA_W-1:0] rf_rd2;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2_reg;
    logic [DATA_W-1:0] op2;
    logic [PC_W-1:0]   dest_sext;
    logic              load_use;
    logic              wb_stall;
    logic              hazard;
    logic              br_hit;

    logic              out_valid_q, out_valid_d;
    logic              br_taken_q,  br_taken_d;
    logic              squash_q,    squash_d;
    logic [OPC_W-1:0]  out_opc_q,   out_opc_d;
    logic [RA_W-1:0]   out_dest_q,  out_dest_d;
    logic [DATA_W-1:0] out_src1_q,  out_src1_d;
    logic [DATA_W-1:0] out_src2_q,  out_src2_d;
    logic [PC_W-1:0]   out_pc_q,    out_pc_d;
    logic [PC_W-1:0]   br_target_q, br_target_d;

    assign f_opc  = OPC_W'(inst_opc(64'(dp.inst), RA_W, OPC_W));
    assign f_src1 = RA_W'(inst_src1(64'(dp.inst), RA_W));
    assign f_src2 = RA_W'(inst_src2(64'(dp.inst), RA_W));
    assign f_dest = RA_W'(inst_dest(64'(dp.inst), RA_W));

    regfile_2r1w #(
        .DATA_W (DATA_W),
        .RA_W   (RA_W)
    ) u_regfile (
        .clk      (clk),
        .reset    (reset),
        .we_i     (dp.wb_en),
        .waddr_i  (dp.wb_addr),
        .wdata_i  (dp.wb_data),
        .raddr1_i (f_src1),
        .rdata1_o (rf_rd1),
        .raddr2_i (f_src2),
        .rdata2_o (rf_rd2)
    );

    // Operand select: R0, then execute forward, then (optionally) writeback, then array.
    always_comb begin
        op1 = rf_rd1;
        if (f_src1 == '0) begin
            op1 = '0;
        end else if (dp.fwd_valid && (dp.fwd_addr == f_src1)) begin
            op1 = dp.fwd_data;
`ifdef DECODE_BYPASS_EN
        end else if (dp.wb_en && (dp.wb_addr == f_src1)) begin
            op1 = dp.wb_data;
`endif
        end
    end

    always_comb begin
        op2_reg = rf_rd2;
        if (f_src2 == '0) begin
            op2_reg = '0;
        end else if (dp.fwd_valid && (dp.fwd_addr == f_src2)) begin
            op2_reg = dp.fwd_data;
`ifdef DECODE_BYPASS_EN
        end else if (dp.wb_en && (dp.wb_addr == f_src2)) begin
            op2_reg = dp.wb_data;
`endif
        end
    end

    assign op2 = dp.imm_sel ? DATA_W'(f_src2) : op2_reg;

    // A load sitting in D/E has no data yet; a consumer must wait one cycle for forwarding.
    assign load_use = out_valid_q && (out_opc_q == LOAD_OPC) && (out_dest_q != '0) &&
                      ((out_dest_q == f_src1) || (!dp.imm_sel && (out_dest_q == f_src2)));

`ifdef DECODE_BYPASS_EN
    assign wb_stall = 1'b0;
`else
    // Without the bypass the array only shows the written value after the edge.
    assign wb_stall = dp.in_valid && dp.wb_en && (dp.wb_addr != '0) &&
                      ((dp.wb_addr == f_src1) || (!dp.imm_sel && (dp.wb_addr == f_src2)));
`endif

    assign hazard      = load_use || wb_stall;
    assign dp.in_ready = !dp.ex_stall && !hazard;
    assign br_hit      = (f_opc == BR_OPC) && (op1 == op2);
    assign dest_sext   = {{(PC_W - RA_W){f_dest[RA_W-1]}}, f_dest};

    always_comb begin
        out_valid_d = out_valid_q;
        br_taken_d  = br_taken_q;
        squash_d    = squash_q;
        out_opc_d   = out_opc_q;
        out_dest_d  = out_dest_q;
        out_src1_d  = out_src1_q;
        out_src2_d  = out_src2_q;
        out_pc_d    = out_pc_q;
        br_target_d = br_target_q;
        // ex_stall leaves every default (hold) in place.
        if (!dp.ex_stall) begin
            if (hazard || !dp.in_valid) begin
                out_valid_d = 1'b0;
                br_taken_d  = 1'b0;
            end else begin
                // Accepted; a pending squash kills this one, which also clears the squash.
                out_valid_d = !squash_q;
                out_opc_d   = f_opc;
                out_dest_d  = f_dest;
                out_src1_d  = op1;
                out_src2_d  = op2;
                out_pc_d    = dp.pc;
                br_taken_d  = !squash_q && br_hit;
                squash_d    = !squash_q && br_hit;
                if (!squash_q && br_hit) begin
                    br_target_d = dp.pc + dest_sext;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            br_taken_q  <= 1'b0;
            squash_q    <= 1'b0;
            out_opc_q   <= '0;
            out_dest_q  <= '0;
            out_src1_q  <= '0;
            out_src2_q  <= '0;
            out_pc_q    <= '0;
            br_target_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            br_taken_q  <= br_taken_d;
            squash_q    <= squash_d;
            out_opc_q   <= out_opc_d;
            out_dest_q  <= out_dest_d;
            out_src1_q  <= out_src1_d;
            out_src2_q  <= out_src2_d;
            out_pc_q    <= out_pc_d;
            br_target_q <= br_target_d;
        end
    end

    assign dp.out_valid = out_valid_q;
    assign dp.out_opc   = out_opc_q;
    assign dp.out_dest  = out_dest_q;
    assign dp.out_src1  = out_src1_q;
    assign dp.out_src2  = out_src2_q;
    assign dp.out_pc    = out_pc_q;
    assign dp.br_taken  = br_taken_q;
    assign dp.br_target = br_target_q;

endmodule

// File: tb/tb_decode_pipe_stage.sv
// tb/tb_decode_pipe_stage.sv - self-checking bench for decode_pipe_stage (default build)
module tb_decode_pipe_stage;

    localparam int DATA_W = 16;
    localparam int RA_W   = 4;
    localparam int OPC_W  = 4;
    localparam int PC_W   = 12;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    decode_pipe_stage_if #(.DATA_W(DATA_W), .RA_W(RA_W), .OPC_W(OPC_W), .PC_W(PC_W)) dp ();

    decode_pipe_stage #(
        .DATA_W(DATA_W), .RA_W(RA_W), .OPC_W(OPC_W), .PC_W(PC_W),
        .LOAD_OPC(4'hA), .BR_OPC(4'hB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .dp    (dp)
    );

    int checks   = 0;
    int failures = 0;

    // Reference state: architectural registers plus what execute should see.
    logic [15:0] m_rf [16];
    logic        m_valid, m_br, m_squash;
    logic [3:0]  m_opc, m_dest;
    logic [15:0] m_s1, m_s2;
    logic [11:0] m_pc, m_tgt;
    logic        last_ready;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] mk(input logic [3:0] opc, input logic [3:0] s1,
                                       input logic [3:0] s2, input logic [3:0] d);
        return {opc, s1, s2, d};
    endfunction

    function automatic logic [15:0] opnd(input logic [3:0] a);
        if (a == 4'd0) return 16'd0;
        if (dp.fwd_valid && dp.fwd_addr == a) return dp.fwd_data;
        return m_rf[a];
    endfunction

    task automatic idle();
        dp.in_valid  = 1'b0;
        dp.inst      = '0;
        dp.pc        = '0;
        dp.imm_sel   = 1'b0;
        dp.wb_en     = 1'b0;
        dp.wb_addr   = '0;
        dp.wb_data   = '0;
        dp.fwd_valid = 1'b0;
        dp.fwd_addr  = '0;
        dp.fwd_data  = '0;
        dp.ex_stall  = 1'b0;
    endtask

    task automatic present(input logic [15:0] inst, input logic [11:0] pc);
        dp.in_valid = 1'b1;
        dp.inst     = inst;
        dp.pc       = pc;
    endtask

    // One clock: check in_ready before the edge, advance the model, check D/E after.
    task automatic cycle();
        logic [3:0]  opc, s1, s2, d;
        logic [15:0] a1, a2;
        logic        lu, ws, hz, hit, taken;
        #1;
        opc = dp.inst[15:12];
        s1  = dp.inst[11:8];
        s2  = dp.inst[7:4];
        d   = dp.inst[3:0];
        lu  = m_valid && m_opc == 4'hA && m_dest != 4'd0 &&
              (m_dest == s1 || (!dp.imm_sel && m_dest == s2));
        ws  = dp.in_valid && dp.wb_en && dp.wb_addr != 4'd0 &&
              (dp.wb_addr == s1 || (!dp.imm_sel && dp.wb_addr == s2));
        hz  = lu || ws;
        a1  = opnd(s1);
        a2  = dp.imm_sel ? {12'd0, s2} : opnd(s2);
        hit = (opc == 4'hB) && (a1 == a2);
        last_ready = dp.in_ready;
        if (!reset) chk("in_ready", dp.in_ready, !dp.ex_stall && !hz);
        @(posedge clk);
        if (reset) begin
            m_valid = 0; m_br = 0; m_squash = 0;
            m_opc = 0; m_dest = 0; m_s1 = 0; m_s2 = 0; m_pc = 0; m_tgt = 0;
            for (int i = 0; i < 16; i++) m_rf[i] = 16'd0;
        end else begin
            if (!dp.ex_stall) begin
                if (hz || !dp.in_valid) begin
                    m_valid = 0;
                    m_br    = 0;
                end else begin
                    taken   = !m_squash && hit;
                    m_valid = !m_squash;
                    m_opc   = opc;
                    m_dest  = d;
                    m_s1    = a1;
                    m_s2    = a2;
                    m_pc    = dp.pc;
                    if (taken) m_tgt = dp.pc + {{8{d[3]}}, d};
                    m_br     = taken;
                    m_squash = taken;
                end
            end
            if (dp.wb_en && dp.wb_addr != 4'd0) m_rf[dp.wb_addr] = dp.wb_data;
        end
        #1;
        chk("out_valid", dp.out_valid, m_valid);
        chk("br_taken", dp.br_taken, m_br);
        if (m_valid) begin
            chk("out_opc", dp.out_opc, m_opc);
            chk("out_dest", dp.out_dest, m_dest);
            chk("out_src1", dp.out_src1, m_s1);
            chk("out_src2", dp.out_src2, m_s2);
            chk("out_pc", dp.out_pc, m_pc);
        end
        if (m_br) chk("br_target", dp.br_target, m_tgt);
    endtask

    task automatic wb_write(input logic [3:0] a, input logic [15:0] v);
        idle();
        dp.wb_en   = 1'b1;
        dp.wb_addr = a;
        dp.wb_data = v;
        cycle();
        idle();
    endtask

    initial begin
        logic [15:0] snap1;
        logic [11:0] snap_pc;
        m_valid = 0; m_br = 0; m_squash = 0; m_opc = 0; m_dest = 0;
        idle();

        // Reset state
        reset = 1'b1;
        cycle();
        cycle();
        chk("rst_opc", dp.out_opc, 0);
        chk("rst_dest", dp.out_dest, 0);
        chk("rst_src1", dp.out_src1, 0);
        chk("rst_src2", dp.out_src2, 0);
        chk("rst_pc", dp.out_pc, 0);
        chk("rst_tgt", dp.br_target, 0);
        reset = 1'b0;
        cycle();
        chk("rst_ready", last_ready, 1);

        // Written register reaches the D/E operand
        wb_write(4'd3, 16'h1234);
        present(mk(4'h1, 4'd3, 4'd0, 4'd5), 12'h001);
        cycle();
        chk("rf_valid", dp.out_valid, 1);
        chk("rf_src1", dp.out_src1, 16'h1234);
        chk("rf_src2", dp.out_src2, 16'h0000);
        idle();

        // Same-cycle writeback: one bubble, then the written value
        present(mk(4'h1, 4'd4, 4'd0, 4'd6), 12'h002);
        dp.wb_en = 1'b1; dp.wb_addr = 4'd4; dp.wb_data = 16'h00FF;
        cycle();
        chk("wbs_ready", last_ready, 0);
        chk("wbs_bubble", dp.out_valid, 0);
        dp.wb_en = 1'b0;
        cycle();
        chk("wbs_src1", dp.out_src1, 16'h00FF);
        idle();

        // Load-use: one bubble, then the forwarded load data
        present(mk(4'hA, 4'd0, 4'd0, 4'd2), 12'h003);
        cycle();
        present(mk(4'h1, 4'd2, 4'd0, 4'd7), 12'h004);
        cycle();
        chk("lu_ready", last_ready, 0);
        chk("lu_bubble", dp.out_valid, 0);
        dp.fwd_valid = 1'b1; dp.fwd_addr = 4'd2; dp.fwd_data = 16'hBEEF;
        cycle();
        chk("lu_ready2", last_ready, 1);
        chk("lu_src1", dp.out_src1, 16'hBEEF);
        idle();

        // Taken branch, squash of the next accepted instruction, then a not-taken branch
        wb_write(4'd1, 16'd7);
        wb_write(4'd2, 16'd7);
        present(mk(4'hB, 4'd1, 4'd2, 4'hE), 12'h010);
        cycle();
        chk("br_taken", dp.br_taken, 1);
        chk("br_target", dp.br_target, 12'h00E);
        chk("br_issues", dp.out_valid, 1);
        present(mk(4'h1, 4'd0, 4'd0, 4'd3), 12'h011);
        cycle();
        chk("br_squash", dp.out_valid, 0);
        chk("br_pulse", dp.br_taken, 0);
        wb_write(4'd2, 16'd8);
        present(mk(4'hB, 4'd1, 4'd2, 4'hE), 12'h010);
        cycle();
        chk("br_not_taken", dp.br_taken, 0);
        chk("br_nt_valid", dp.out_valid, 1);
        idle();

        // ex_stall holds D/E for 3 cycles while the register file still takes writes
        present(mk(4'h2, 4'd1, 4'd0, 4'd9), 12'h030);
        cycle();
        snap1   = dp.out_src1;
        snap_pc = dp.out_pc;
        present(mk(4'h3, 4'd1, 4'd1, 4'd1), 12'h031);
        dp.ex_stall = 1'b1;
        dp.wb_en = 1'b1; dp.wb_addr = 4'd5; dp.wb_data = 16'h55AA;
        cycle();
        dp.wb_en = 1'b0;
        cycle();
        cycle();
        chk("stall_ready", last_ready, 0);
        chk("stall_src1", dp.out_src1, snap1);
        chk("stall_pc", dp.out_pc, snap_pc);
        dp.ex_stall = 1'b0;
        present(mk(4'h1, 4'd5, 4'd0, 4'd1), 12'h032);
        cycle();
        chk("stall_wb_landed", dp.out_src1, 16'h55AA);

        // Reset while br_taken is high (and execute stalled) drops the pending squash
        present(mk(4'hB, 4'd1, 4'd1, 4'hE), 12'h020);
        cycle();
        chk("rb_taken", dp.br_taken, 1);
        reset = 1'b1;
        dp.ex_stall = 1'b1;
        present(mk(4'h1, 4'd1, 4'd0, 4'd3), 12'h021);
        cycle();
        chk("rb_valid", dp.out_valid, 0);
        chk("rb_br", dp.br_taken, 0);
        reset = 1'b0;
        dp.ex_stall = 1'b0;
        cycle();
        chk("rb_no_squash", dp.out_valid, 1);
        chk("rb_r1_cleared", dp.out_src1, 0);

        // Reset during a load-use bubble, then every register reads back zero
        wb_write(4'd2, 16'h4444);
        present(mk(4'hA, 4'd0, 4'd0, 4'd2), 12'h040);
        cycle();
        present(mk(4'h1, 4'd2, 4'd0, 4'd4), 12'h041);
        reset = 1'b1;
        cycle();
        chk("rl_valid", dp.out_valid, 0);
        chk("rl_br", dp.br_taken, 0);
        reset = 1'b0;
        for (int r = 1; r < 16; r++) begin
            present(mk(4'h1, 4'(r), 4'(r), 4'd0), 12'(r));
            cycle();
            chk("rl_zero_s1", dp.out_src1, 0);
            chk("rl_zero_s2", dp.out_src2, 0);
        end
        idle();

        // Randomised traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            logic [3:0] opc;
            case ($urandom_range(0, 3))
                0:       opc = 4'hA;
                1:       opc = 4'hB;
                default: opc = 4'($urandom_range(0, 15));
            endcase
            dp.in_valid  = ($urandom_range(0, 3) != 0);
            dp.inst      = mk(opc, 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
                              4'($urandom_range(0, 15)));
            dp.pc        = 12'($urandom);
            dp.imm_sel   = ($urandom_range(0, 3) == 0);
            dp.wb_en     = ($urandom_range(0, 2) == 0);
            dp.wb_addr   = 4'($urandom_range(0, 7));
            dp.wb_data   = 16'($urandom_range(0, 3));
            dp.fwd_valid = ($urandom_range(0, 2) == 0);
            dp.fwd_addr  = 4'($urandom_range(0, 7));
            dp.fwd_data  = 16'($urandom_range(0, 3));
            dp.ex_stall  = ($urandom_range(0, 4) == 0);
            cycle();
        end
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
